huffman_decoder: RTL and testbench
==================================

# huffman_decoder

Decodes a serial Huffman bitstream back into gray-level symbols A1..A6 using the code table (HCn/Mn) produced by the Huffman encoder stage. It sits downstream of the encoder: it latches the table on `code_valid`, consumes one bit per accepted beat, and emits one 3-bit symbol per matched codeword under a valid/ready handshake. It asserts `done` after NSYM symbols and `err` when no code matches within 8 bits.

## Interface
- NSYM, 100: symbols per frame; `done` asserts after this many output handshakes.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- code_valid  in  1  single-cycle strobe; latches the table below
- HC1..HC6  in  8 each  codewords, right-aligned; first-transmitted bit is the MSB of the code field
- M1..M6  in  8 each  masks of contiguous LSB ones; popcount = code length; 0 disables the entry
- bit_valid  in  1  `bit_in` is valid
- bit_in  in  1  stream bit
- bit_ready  out  1  decoder accepts a bit this cycle
- sym_valid  out  1  `sym_data` is valid; held until accepted
- sym_data  out  3  decoded symbol, 1..6
- sym_ready  in  1  consumer accepts the symbol
- done  out  1  frame complete; sticky
- err  out  1  undecodable stream; sticky

## Operation
- Reset values: state IDLE; table, shift register, length, and symbol count all 0. Outputs `bit_ready`, `sym_valid`, `done`, `err` are 0; `sym_data` is 0.
- States:
  - IDLE: wait for `code_valid`.
  - DECODE: accept bits.
  - HOLD: present a symbol.
  - DONE
  - ERR
- `code_valid` in any state:
  - latches all HCn/Mn;
  - clears the shift register, length, and symbol count;
  - clears `sym_valid`, `done`, and `err`;
  - enters DECODE next cycle.
- `bit_ready` = 1 only in DECODE.
- Accept = `bit_valid & bit_ready`. On accept: shift = {shift[6:0], bit_in}; len = len + 1, saturating at 8.
- Match for entry n, evaluated on the post-shift value: Mn != 0, len_new == popcount(Mn), and (shift_new & Mn) == HCn.
- If several entries match, the lowest n wins; the table is prefix-free, so this case does not arise with valid tables.
- On a match: `sym_data` <= n, `sym_valid` <= 1, shift/len cleared, go to HOLD.
- No match with len_new == 8: `err` <= 1, go to ERR.
- HOLD, on `sym_valid & sym_ready`:
  - `sym_valid` <= 0;
  - count + 1;
  - if count + 1 == NSYM: `done` <= 1, go to DONE;
  - else return to DECODE.
- `sym_data` is stable while `sym_valid` = 1.
- DONE and ERR ignore bits (`bit_ready` = 0) until `code_valid` or reset.
- Count width is $clog2(NSYM+1). Len is 4 bits.

## Timing
- Latency: the symbol becomes valid on the cycle after the last bit of its codeword is accepted.
- Back-to-back operation: if `sym_ready` = 1 while `sym_valid` = 1, the decoder is back in DECODE on the next cycle. Throughput is 1 bit per cycle plus one bubble cycle per symbol.
- `bit_ready` drops in the cycle `sym_valid` rises, so no bit is lost or double-consumed.
- `code_valid` coincident with a bit accept: `code_valid` wins and the bit is discarded.
- Reset mid-frame: all state and outputs go to their reset values immediately (asynchronous).

## Structure
- huffman_pkg holds:
  - state enum {IDLE, DECODE, HOLD, DONE, ERR};
  - SYM_W = 3, CODE_W = 8, NUM_SYM = 6;
  - a popcount function for 8-bit masks.
- Sub-module huffman_code_match, purely combinational:
  - inputs: shift_new, len_new, the 6 latched HC/M pairs;
  - outputs: hit and idx[2:0], with the lowest index winning.
- The top level holds the FSM, table registers, shift/len, and the counter.

## Test plan
Test table T:
- A1 = "1": HC 01, M 01
- A2 = "00": HC 00, M 03
- A3 = "011": HC 03, M 07
- A4 = "0100": HC 04, M 0F
- A5 = "01010": HC 0A, M 1F
- A6 = "01011": HC 0B, M 1F

Scenarios:
- Basic decode: load T; stream 1,0,0,0,1,1 with `sym_ready` = 1 → symbols 1, 2, 3, each valid one cycle after its last bit.
- Longest codes: load T; stream 0,1,0,1,0, 0,1,0,1,1, 0,1,0,0 → symbols 5, 6, 4.
- Backpressure: load T; send "1" and hold `sym_ready` = 0 for 5 cycles → `sym_valid` = 1 and `sym_data` = 1 stable, `bit_ready` = 0 throughout; no bits consumed.
- Frame end (NSYM = 4): send four "1" codes → `done` asserts after the 4th handshake, `bit_ready` stays 0, and a new `code_valid` clears `done`.
- Error: load A1 only (others M = 0); send 8 zeros → `err` = 1 after the 8th accepted bit, and no further bits are accepted.
- Reset: assert `reset` while in HOLD → `sym_valid`, `done`, `err` = 0 and state IDLE without a clock edge; bits are ignored until `code_valid`.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types, widths and helpers for the Huffman decoder block.
package huffman_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        HOLD   = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam int SYM_W   = 3;
    localparam int CODE_W  = 8;
    localparam int NUM_SYM = 6;

    // Number of ones in an 8-bit mask, i.e. the code length it describes.
    function automatic logic [3:0] popcount(input logic [CODE_W-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < CODE_W; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Combinational codeword lookup: compares the candidate bit window against
// every enabled table entry and reports the lowest-numbered hit.
module huffman_code_match
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0]               shift_new,
    input  logic [3:0]                      len_new,
    input  logic [NUM_SYM-1:0][CODE_W-1:0]  hc,
    input  logic [NUM_SYM-1:0][CODE_W-1:0]  m,
    output logic                            hit,
    output logic [SYM_W-1:0]                idx
);

    // Scan from the highest entry down so the lowest matching entry is the last writer.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int n = NUM_SYM - 1; n >= 0; n--) begin
            if ((m[n] != '0) &&
                (len_new == popcount(m[n])) &&
                ((shift_new & m[n]) == hc[n])) begin
                hit = 1'b1;
                idx = SYM_W'(n + 1);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman bitstream decoder: latches a 6-entry code table, shifts in
// one bit per accepted beat and emits the matching symbol number 1..6.
//
// Handshakes: a bit transfers on a cycle where bit_valid & bit_ready are both
// high at the rising edge; a symbol transfers where sym_valid & sym_ready are
// both high. sym_valid/sym_data are held unchanged until that transfer.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int NSYM = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym_data,
    input  logic              sym_ready,
    output logic              done,
    output logic              err,
    output state_t            state
);

    localparam int CNT_W = $clog2(NSYM + 1);

    state_t                           state_q;
    state_t                           state_d;
    logic [NUM_SYM-1:0][CODE_W-1:0]   hc_q;
    logic [NUM_SYM-1:0][CODE_W-1:0]   m_q;
    // Only the low 7 bits of the window survive the next shift, so bit 7 is
    // never stored; the full 8-bit window exists only as shift_new.
    logic [CODE_W-2:0]                shift_q;
    logic [3:0]                       len_q;
    logic [CNT_W-1:0]                 count_q;

    logic [CODE_W-1:0]                shift_new;
    logic [3:0]                       len_new;
    logic                             len_full;
    logic                             accept;
    logic                             sym_xfer;
    logic [CNT_W-1:0]                 count_inc;
    logic                             last_sym;
    logic                             hit;
    logic [SYM_W-1:0]                 idx;

    assign shift_new = {shift_q, bit_in};
    assign len_new   = (len_q == 4'(CODE_W)) ? 4'(CODE_W) : len_q + 4'd1;
    assign len_full  = (len_new == 4'(CODE_W));
    assign accept    = bit_valid & bit_ready;
    assign sym_xfer  = (state_q == HOLD) & sym_valid & sym_ready;
    assign count_inc = count_q + 1'b1;
    assign last_sym  = (count_inc == CNT_W'(NSYM));
    assign state     = state_q;

    huffman_code_match u_match (
        .shift_new (shift_new),
        .len_new   (len_new),
        .hc        (hc_q),
        .m         (m_q),
        .hit       (hit),
        .idx       (idx)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bit_ready; a table load overrides everything else.
    always_comb begin
        state_d   = state_q;
        bit_ready = (state_q == DECODE);
        if (code_valid) begin
            state_d = DECODE;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                DECODE: begin
                    if (accept) begin
                        if (hit) begin
                            state_d = HOLD;
                        end else if (len_full) begin
                            state_d = ERR;
                        end
                    end
                end
                HOLD: begin
                    if (sym_xfer) begin
                        state_d = last_sym ? DONE : DECODE;
                    end
                end
                DONE:    state_d = DONE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Table, bit window, symbol count and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q      <= '0;
            m_q       <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            count_q   <= '0;
            sym_valid <= 1'b0;
            sym_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (code_valid) begin
            // A coincident bit is dropped: the new table starts from a clean window.
            hc_q      <= {HC6, HC5, HC4, HC3, HC2, HC1};
            m_q       <= {M6, M5, M4, M3, M2, M1};
            shift_q   <= '0;
            len_q     <= '0;
            count_q   <= '0;
            sym_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            if (hit) begin
                sym_data  <= idx;
                sym_valid <= 1'b1;
                shift_q   <= '0;
                len_q     <= '0;
            end else begin
                shift_q <= shift_new[CODE_W-2:0];
                len_q   <= len_new;
                if (len_full) begin
                    err <= 1'b1;
                end
            end
        end else if (sym_xfer) begin
            sym_valid <= 1'b0;
            count_q   <= count_inc;
            if (last_sym) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder using the reference table T and a
// four-symbol frame so frame completion is reachable quickly.
module tb_huffman_decoder;
    import huffman_pkg::*;

    localparam int NSYM_TB = 4;

    logic              clk;
    logic              reset;
    logic              code_valid;
    logic [CODE_W-1:0] hc [NUM_SYM];
    logic [CODE_W-1:0] mk [NUM_SYM];
    logic              bit_valid;
    logic              bit_in;
    logic              bit_ready;
    logic              sym_valid;
    logic [SYM_W-1:0]  sym_data;
    logic              sym_ready;
    logic              done;
    logic              err;
    state_t            state;

    int n_checks;
    int n_errors;
    logic [SYM_W-1:0] exp_q [$];

    huffman_decoder #(.NSYM(NSYM_TB)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc[0]),
        .HC2        (hc[1]),
        .HC3        (hc[2]),
        .HC4        (hc[3]),
        .HC5        (hc[4]),
        .HC6        (hc[5]),
        .M1         (mk[0]),
        .M2         (mk[1]),
        .M3         (mk[2]),
        .M4         (mk[3]),
        .M5         (mk[4]),
        .M6         (mk[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .done       (done),
        .err        (err),
        .state      (state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_table_t();
        hc = '{8'h01, 8'h00, 8'h03, 8'h04, 8'h0A, 8'h0B};
        mk = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    endtask

    task automatic set_table_a1_only();
        hc = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        mk = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    endtask

    // Pulse code_valid for one cycle and confirm the decoder is ready to decode.
    task automatic load_table();
        @(negedge clk);
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        check("load_state", 32'(state), 32'(DECODE));
        check("load_done", 32'(done), 32'd0);
        check("load_err", 32'(err), 32'd0);
        check("load_sym_valid", 32'(sym_valid), 32'd0);
    endtask

    // Send one codeword MSB first, then check the symbol appears the next cycle.
    task automatic send_code(input logic [7:0] code, input int len, input logic [SYM_W-1:0] sym);
        int t;
        exp_q.push_back(sym);
        for (int i = len - 1; i >= 0; i--) begin
            @(negedge clk);
            t = 0;
            while (!bit_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!bit_ready) check("bit_ready_timeout", 32'(bit_ready), 32'd1);
            check("no_early_valid", 32'(sym_valid), 32'd0);
            bit_valid = 1'b1;
            bit_in    = code[i];
        end
        @(negedge clk);
        bit_valid = 1'b0;
        check("sym_valid", 32'(sym_valid), 32'd1);
        check("sym_data", 32'(sym_data), 32'(exp_q.pop_front()));
        check("bit_ready_low_in_hold", 32'(bit_ready), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        sym_ready  = 1'b1;
        set_table_t();

        // Reset values.
        #1;
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_bit_ready", 32'(bit_ready), 32'd0);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_sym_data", 32'(sym_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        bit_valid = 1'b1;
        @(negedge clk);
        check("idle_ignores_bits", 32'(bit_ready), 32'd0);
        check("idle_state", 32'(state), 32'(IDLE));
        bit_valid = 1'b0;

        // Basic decode: 1 | 00 | 011.
        load_table();
        send_code(8'h01, 1, 3'd1);
        send_code(8'h00, 2, 3'd2);
        send_code(8'h03, 3, 3'd3);

        // Longest codes: 01010 | 01011 | 0100.
        load_table();
        send_code(8'h0A, 5, 3'd5);
        send_code(8'h0B, 5, 3'd6);
        send_code(8'h04, 4, 3'd4);

        // code_valid coincident with an accepted bit: bit dropped, window cleared.
        load_table();
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        @(negedge clk);
        code_valid = 1'b1;
        bit_in     = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        check("coincident_no_sym", 32'(sym_valid), 32'd0);
        check("coincident_state", 32'(state), 32'(DECODE));
        send_code(8'h01, 1, 3'd1);

        // Backpressure: hold the symbol for 5 cycles while bits are offered.
        load_table();
        sym_ready = 1'b0;
        send_code(8'h01, 1, 3'd1);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_sym_valid", 32'(sym_valid), 32'd1);
            check("bp_sym_data", 32'(sym_data), 32'd1);
            check("bp_bit_ready", 32'(bit_ready), 32'd0);
            check("bp_state", 32'(state), 32'(HOLD));
        end
        bit_valid = 1'b0;
        sym_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 32'(sym_valid), 32'd0);
        check("bp_back_decode", 32'(state), 32'(DECODE));
        send_code(8'h00, 2, 3'd2);

        // Frame end after four symbols.
        load_table();
        send_code(8'h01, 1, 3'd1);
        send_code(8'h01, 1, 3'd1);
        send_code(8'h01, 1, 3'd1);
        send_code(8'h01, 1, 3'd1);
        check("done_before_last_xfer", 32'(done), 32'd0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(negedge clk);
        check("frame_done", 32'(done), 32'd1);
        check("frame_state", 32'(state), 32'(DONE));
        check("frame_sym_valid", 32'(sym_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("done_bit_ready", 32'(bit_ready), 32'd0);
            check("done_sticky", 32'(done), 32'd1);
        end
        bit_valid = 1'b0;
        load_table();

        // Undecodable stream: only A1 enabled, eight zeros.
        set_table_a1_only();
        load_table();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("err_bit_ready", 32'(bit_ready), 32'd1);
            if (k == 7) check("err_not_yet", 32'(err), 32'd0);
            bit_valid = 1'b1;
            bit_in    = 1'b0;
        end
        @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        check("err_state", 32'(state), 32'(ERR));
        check("err_no_sym", 32'(sym_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("err_ignores_bits", 32'(bit_ready), 32'd0);
            check("err_sticky", 32'(err), 32'd1);
        end
        bit_valid = 1'b0;

        // Asynchronous reset while holding a symbol.
        set_table_t();
        load_table();
        sym_ready = 1'b0;
        send_code(8'h01, 1, 3'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_sym_valid", 32'(sym_valid), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_state", 32'(state), 32'(IDLE));
        check("arst_sym_data", 32'(sym_data), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        sym_ready = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_bit_ready", 32'(bit_ready), 32'd0);
            check("post_rst_state", 32'(state), 32'(IDLE));
        end
        bit_valid = 1'b0;
        load_table();
        send_code(8'h03, 3, 3'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
